// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_boot_loader
// Description : Streams a program image (header N, N instruction words,
//               checksum word) into the instruction memory write port and
//               holds the core in reset until the image has been written
//               and its additive checksum verified. A malformed image
//               (oversize header or checksum mismatch) latches a sticky
//               error and keeps the core halted until the next start.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   one-cycle pulse, begins a load from IDLE/RUN/ERROR
//   in_valid     in   stream word valid
//   in_data      in   stream word (header, instruction or checksum)
//   in_ready     out  stream word accepted this cycle when in_valid is high
//   imem_we      out  instruction memory write enable (one pulse per word)
//   imem_addr    out  instruction memory word address
//   imem_wdata   out  instruction memory write data
//   core_run     out  1 = core released, 0 = core held in reset
//   busy         out  load in progress (HDR, DATA, SUM)
//   error        out  sticky image error
//   words_loaded out  instruction words written in the current load
//
// Revision    : 1.0  initial release
// ============================================================================
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  core_run,
    output logic                  busy,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    // Memory capacity, held one bit wider than a stream word so the header
    // comparison stays a plain unsigned compare over the full word.
    localparam logic [DATA_WIDTH:0] c_depth =
        {{DATA_WIDTH{1'b0}}, 1'b1} << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_SUM   = 3'd3,
        S_RUN   = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic                    r_in_ready;
    logic                    r_busy;
    logic                    r_core_run;
    logic                    r_error;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [ADDR_WIDTH:0]     r_count;
    logic [ADDR_WIDTH:0]     r_n;
    logic [DATA_WIDTH-1:0]   r_acc;

    logic                    w_xfer;
    logic                    w_hdr_over;
    logic                    w_hdr_zero;
    logic                    w_last_word;
    logic                    w_enter_hdr;
    logic                    w_next_busy;
    logic [ADDR_WIDTH:0]     w_count_inc;
    logic [DATA_WIDTH-1:0]   w_acc_sum;

    assign w_xfer      = in_valid && r_in_ready;
    assign w_hdr_over  = {1'b0, in_data} > c_depth;
    assign w_hdr_zero  = (in_data == '0);
    assign w_count_inc = r_count + 1'b1;
    assign w_last_word = (w_count_inc == r_n);
    assign w_acc_sum   = r_acc + in_data;

    // A load can only be (re)started from a non-busy state.
    assign w_enter_hdr = start && (r_state == S_IDLE || r_state == S_RUN ||
                                   r_state == S_ERROR);

    assign w_next_busy = (w_state_next == S_HDR) || (w_state_next == S_DATA) ||
                         (w_state_next == S_SUM);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_RUN, S_ERROR: begin
                if (start) begin
                    w_state_next = S_HDR;
                end
            end
            S_HDR: begin
                if (w_xfer) begin
                    if (w_hdr_over) begin
                        w_state_next = S_ERROR;
                    end else if (w_hdr_zero) begin
                        w_state_next = S_SUM;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_xfer && w_last_word) begin
                    w_state_next = S_SUM;
                end
            end
            S_SUM: begin
                if (w_xfer) begin
                    // The accumulator already holds the final data word.
                    if (in_data == r_acc) begin
                        w_state_next = S_RUN;
                    end else begin
                        w_state_next = S_ERROR;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Status outputs, registered from the next state so they change on the
    // same edge as the state itself (core_run drops as busy rises).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_core_run <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_in_ready <= w_next_busy;
            r_busy     <= w_next_busy;
            r_core_run <= (w_state_next == S_RUN);
            r_error    <= (w_state_next == S_ERROR);
        end
    end

    // ------------------------------------------------------------------
    // Datapath: header latch, word counter, checksum accumulator and the
    // one-cycle-delayed memory write port.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_count <= '0;
            r_n     <= '0;
            r_acc   <= '0;
        end else begin
            r_we <= 1'b0;

            if (w_enter_hdr) begin
                r_count <= '0;
                r_acc   <= '0;
            end

            // Only legal headers (N <= DEPTH) are used afterwards, and those
            // fit in ADDR_WIDTH+1 bits.
            if (w_xfer && r_state == S_HDR) begin
                r_n <= in_data[ADDR_WIDTH:0];
            end

            if (w_xfer && r_state == S_DATA) begin
                r_we    <= 1'b1;
                r_addr  <= r_count[ADDR_WIDTH-1:0];
                r_wdata <= in_data;
                r_acc   <= w_acc_sum;
                r_count <= w_count_inc;
            end
        end
    end

    assign in_ready     = r_in_ready;
    assign busy         = r_busy;
    assign core_run     = r_core_run;
    assign error        = r_error;
    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign words_loaded = r_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_boot_loader
// Description : Self-checking bench for imem_boot_loader. Images are built
//               from random words; the expected memory contents, checksum
//               and final status come from a simple image-level model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_imem_boot_loader;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic          core_run;
    logic          busy;
    logic          error;
    logic [AW:0]   words_loaded;

    imem_boot_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_run     (core_run),
        .busy         (busy),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Image under test and captured memory writes.
    logic [DW-1:0] img [0:DEPTH-1];
    logic [AW-1:0] cap_addr [0:8191];
    logic [DW-1:0] cap_data [0:8191];
    int            cap_n = 0;

    always @(negedge clk) begin
        if (imem_we === 1'b1 && cap_n < 8192) begin
            cap_addr[cap_n] = imem_addr;
            cap_data[cap_n] = imem_wdata;
            cap_n = cap_n + 1;
        end
    end

    // Reference checksum: sum of the instruction words, wrapping.
    function automatic logic [DW-1:0] model_sum(input int n);
        logic [DW-1:0] s = '0;
        for (int i = 0; i < n; i++) s = s + img[i];
        return s;
    endfunction

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) img[i] = $urandom;
    endtask

    // Entered and left at a falling edge.
    task automatic send_word(input logic [DW-1:0] d);
        int w = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (in_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (in_ready !== 1'b1) begin
            n_total++;
            $display("FAIL send_word_timeout in_ready=%b want 1", in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Stream header hdr, img[0..n-1] (unless the header is oversize) and cks.
    task automatic load_image(input int n, input logic [DW-1:0] hdr,
                              input logic [DW-1:0] cks, input bit gaps,
                              input int start_at);
        pulse_start();
        send_word(hdr);
        if (hdr > DEPTH) return;
        for (int i = 0; i < n; i++) begin
            if (i == start_at) start = 1'b1;
            send_word(img[i]);
            start = 1'b0;
            if (gaps) @(negedge clk);
        end
        send_word(cks);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF; start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_total++;
            if ({in_ready, imem_we, imem_addr, imem_wdata, core_run, busy,
                 error, words_loaded} !== '0)
                $display("FAIL reset_idle cyc=%0d rdy=%b we=%b addr=%h wd=%h run=%b busy=%b err=%b wl=%0d want all 0",
                         i, in_ready, imem_we, imem_addr, imem_wdata, core_run, busy, error, words_loaded);
            else n_pass++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_good_load();
        img[0] = 32'h00500093; img[1] = 32'h00300113; img[2] = 32'h002081B3;
        pulse_start();
        send_word(32'd3);
        for (int i = 0; i < 3; i++) begin
            send_word(img[i]);
            n_total++;
            if (imem_we !== 1'b1 || imem_addr !== AW'(i) || imem_wdata !== img[i])
                $display("FAIL good_write%0d we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                         i, imem_we, imem_addr, imem_wdata, i, img[i]);
            else n_pass++;
        end
        send_word(32'h00A08359);
        n_total++;
        if (core_run !== 1'b1 || busy !== 1'b0 || error !== 1'b0 ||
            in_ready !== 1'b0 || imem_we !== 1'b0 || words_loaded !== 11'd3)
            $display("FAIL good_done run=%b busy=%b err=%b rdy=%b we=%b wl=%0d want run=1 busy=0 err=0 rdy=0 we=0 wl=3",
                     core_run, busy, error, in_ready, imem_we, words_loaded);
        else n_pass++;
    endtask

    task automatic test_bad_checksum();
        load_image(3, 32'd3, 32'h00A0835A, 1'b0, -1);
        n_total++;
        if (error !== 1'b1 || core_run !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0)
            $display("FAIL bad_cks err=%b run=%b rdy=%b busy=%b want err=1 run=0 rdy=0 busy=0",
                     error, core_run, in_ready, busy);
        else n_pass++;
        load_image(3, 32'd3, 32'h00A08359, 1'b0, -1);
        n_total++;
        if (error !== 1'b0 || core_run !== 1'b1)
            $display("FAIL bad_cks_recover err=%b run=%b want err=0 run=1", error, core_run);
        else n_pass++;
    endtask

    task automatic test_oversize();
        int base;
        int bad;
        base = cap_n;
        load_image(0, 32'd1025, 32'd0, 1'b0, -1);
        n_total++;
        if (error !== 1'b1 || busy !== 1'b0 || core_run !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL oversize_hdr err=%b busy=%b run=%b rdy=%b want err=1 busy=0 run=0 rdy=0",
                     error, busy, core_run, in_ready);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_total++;
        if (cap_n != base) $display("FAIL oversize_writes got=%0d want 0", cap_n - base);
        else n_pass++;

        fill_random(DEPTH);
        base = cap_n;
        load_image(DEPTH, 32'd1024, model_sum(DEPTH), 1'b0, -1);
        bad = (cap_n - base != DEPTH) ? 1 : 0;
        for (int i = 0; i < DEPTH && base + i < cap_n; i++)
            if (cap_addr[base+i] !== AW'(i) || cap_data[base+i] !== img[i]) bad++;
        n_total++;
        if (bad != 0 || words_loaded !== 11'd1024 || core_run !== 1'b1 || error !== 1'b0)
            $display("FAIL full_depth bad_writes=%0d nwr=%0d wl=%0d run=%b err=%b want 0 1024 1024 1 0",
                     bad, cap_n - base, words_loaded, core_run, error);
        else n_pass++;
    endtask

    task automatic test_zero_len();
        int base;
        base = cap_n;
        load_image(0, 32'd0, 32'd0, 1'b0, -1);
        n_total++;
        if (core_run !== 1'b1 || error !== 1'b0 || words_loaded !== '0 || cap_n != base)
            $display("FAIL zero_len run=%b err=%b wl=%0d nwr=%0d want 1 0 0 0",
                     core_run, error, words_loaded, cap_n - base);
        else n_pass++;
        load_image(0, 32'd0, 32'd5, 1'b0, -1);
        n_total++;
        if (core_run !== 1'b0 || error !== 1'b1)
            $display("FAIL zero_len_badcks run=%b err=%b want run=0 err=1", core_run, error);
        else n_pass++;
    endtask

    task automatic test_toggle_valid();
        int b1;
        int b2;
        int bad;
        fill_random(7);
        b1 = cap_n;
        load_image(7, 32'd7, model_sum(7), 1'b0, -1);
        b2 = cap_n;
        load_image(7, 32'd7, model_sum(7), 1'b1, -1);
        bad = (b2 - b1 != 7 || cap_n - b2 != 7) ? 1 : 0;
        for (int i = 0; i < 7 && b2 + i < cap_n; i++)
            if (cap_addr[b2+i] !== cap_addr[b1+i] || cap_data[b2+i] !== cap_data[b1+i] ||
                cap_addr[b2+i] !== AW'(i) || cap_data[b2+i] !== img[i]) bad++;
        n_total++;
        if (bad != 0 || core_run !== 1'b1 || words_loaded !== 11'd7)
            $display("FAIL toggle_valid bad_writes=%0d run=%b wl=%0d want 0 1 7", bad, core_run, words_loaded);
        else n_pass++;
    endtask

    task automatic test_start_during_data();
        int base;
        int bad;
        fill_random(6);
        base = cap_n;
        load_image(6, 32'd6, model_sum(6), 1'b0, 3);
        bad = (cap_n - base != 6) ? 1 : 0;
        for (int i = 0; i < 6 && base + i < cap_n; i++)
            if (cap_addr[base+i] !== AW'(i) || cap_data[base+i] !== img[i]) bad++;
        n_total++;
        if (bad != 0 || core_run !== 1'b1 || words_loaded !== 11'd6)
            $display("FAIL start_in_data bad_writes=%0d run=%b wl=%0d want 0 1 6", bad, core_run, words_loaded);
        else n_pass++;
    endtask

    task automatic test_reset_mid_load();
        int base;
        int bad;
        fill_random(3);
        pulse_start();
        send_word(32'd3);
        send_word(img[0]);
        send_word(img[1]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, core_run, busy,
             error, words_loaded} !== '0)
            $display("FAIL reset_mid rdy=%b we=%b addr=%h wd=%h run=%b busy=%b err=%b wl=%0d want all 0",
                     in_ready, imem_we, imem_addr, imem_wdata, core_run, busy, error, words_loaded);
        else n_pass++;
        fill_random(3);
        base = cap_n;
        load_image(3, 32'd3, model_sum(3), 1'b0, -1);
        bad = (cap_n - base != 3) ? 1 : 0;
        for (int i = 0; i < 3 && base + i < cap_n; i++)
            if (cap_addr[base+i] !== AW'(i) || cap_data[base+i] !== img[i]) bad++;
        n_total++;
        if (bad != 0 || core_run !== 1'b1)
            $display("FAIL reset_mid_restart bad_writes=%0d run=%b want 0 1", bad, core_run);
        else n_pass++;
    endtask

    task automatic test_start_from_run();
        n_total++;
        if (core_run !== 1'b1) $display("FAIL run_before_start run=%b want 1", core_run);
        else n_pass++;
        pulse_start();
        n_total++;
        if (core_run !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1 || words_loaded !== '0)
            $display("FAIL start_from_run run=%b busy=%b rdy=%b wl=%0d want 0 1 1 0",
                     core_run, busy, in_ready, words_loaded);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random_images();
        for (int it = 0; it < 8; it++) begin
            int n;
            bit good;
            int base;
            int bad;
            logic [DW-1:0] cks;
            n    = $urandom_range(1, 20);
            good = ($urandom_range(0, 1) == 1);
            fill_random(n);
            cks  = good ? model_sum(n) : model_sum(n) + DW'($urandom_range(1, 1000));
            base = cap_n;
            load_image(n, DW'(n), cks, ($urandom_range(0, 1) == 1), -1);
            bad = (cap_n - base != n) ? 1 : 0;
            for (int i = 0; i < n && base + i < cap_n; i++)
                if (cap_addr[base+i] !== AW'(i) || cap_data[base+i] !== img[i]) bad++;
            n_total++;
            if (bad != 0 || core_run !== good || error !== !good ||
                words_loaded !== (AW+1)'(n) || busy !== 1'b0)
                $display("FAIL random_img%0d n=%0d bad_writes=%0d run=%b err=%b wl=%0d busy=%b want run=%b err=%b wl=%0d busy=0",
                         it, n, bad, core_run, error, words_loaded, busy, good, !good, n);
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        @(negedge clk);
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_oversize();
        test_zero_len();
        test_toggle_valid();
        test_start_during_data();
        test_reset_mid_load();
        test_start_from_run();
        test_random_images();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
